io_input: RTL and testbench

Memory-mapped input device: the read-side counterpart of the output device on the CPU's 4-phase req/ack I/O handshake. It buffers bytes from a host-side byte stream (valid/ready plus end-of-stream flag) in a small FIFO. It returns one byte per CPU read request, zero-extended to `WORD_SIZE`, or an all-ones word once the stream is exhausted. It sits between the CPU's I/O port and the simulation or host byte source.

---
 rtl/io_input_if.sv | 26 ++
 rtl/io_input.sv | 105 ++++++++++
 tb/tb_io_input.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_input_if.sv
// CPU read port and host byte-stream port of the memory-mapped input device.
// The master side issues read requests and supplies bytes. The slave side
// is the device itself.
interface io_input_if #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 16
);
  logic                     req;
  logic                     ack;
  logic [WORD_SIZE-1:0]     data;
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               in_byte;
  logic                     in_eof;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output req, in_valid, in_byte, in_eof,
    input  ack, data, in_ready, count
  );

  modport slave (
    input  req, in_valid, in_byte, in_eof,
    output ack, data, in_ready, count
  );
endinterface

// File: rtl/io_input.sv
// Memory-mapped input device. Host bytes are buffered in a circular FIFO and
// returned one per 4-phase CPU read, zero-extended to WORD_SIZE. Once the
// stream has ended and the FIFO has drained, every read returns all ones.
module io_input #(
  parameter int DEPTH     = 16,  // power of two, >= 2
  parameter int WORD_SIZE = 32
) (
  input logic       clk,
  input logic       areset,
  io_input_if.slave bus
);

  localparam int PTR_W         = $clog2(DEPTH);
  localparam int CNT_W         = PTR_W + 1;
  localparam int IO_STATE_BITS = 2;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [IO_STATE_BITS-1:0] {
    IO_WAITREQ = 2'd0,
    IO_DOWORK  = 2'd1,
    IO_WAITACK = 2'd2
  } io_state_t;

  io_state_t            state_q, state_d;
  logic [7:0]           mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count_q;
  logic                 eof_seen;
  logic [WORD_SIZE-1:0] data_q;
  logic                 push, pop;
  logic                 have_byte;

  assign have_byte     = (count_q != '0);
  assign bus.in_ready  = (count_q != FULL_COUNT) && !eof_seen;
  assign push          = bus.in_valid && bus.in_ready;
  // The pop is tied to the single DOWORK cycle of a read; an empty FIFO in
  // DOWORK means the EOF answer is being produced instead.
  assign pop           = (state_q == IO_DOWORK) && have_byte;

  assign bus.ack   = (state_q == IO_WAITACK);
  assign bus.data  = data_q;
  assign bus.count = count_q;

  // Handshake state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values of the others, independent of block ordering.
    if (areset) state_q <= IO_WAITREQ;
    else        state_q <= state_d;
  end

  // Handshake next-state logic. A read with nothing buffered and no EOF
  // simply blocks in WAITREQ.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives
    // state_d, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IO_WAITREQ: if (bus.req && (have_byte || eof_seen)) state_d = IO_DOWORK;
      IO_DOWORK:  state_d = IO_WAITACK;
      IO_WAITACK: if (!bus.req) state_d = IO_WAITREQ;
      default:    state_d = IO_WAITREQ;
    endcase
  end

  // Pointers, occupancy and the sticky end-of-stream flag.
  always_ff @(posedge clk) begin
    if (areset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      eof_seen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A byte arriving with in_eof is still accepted because push above
      // uses the pre-edge eof_seen.
      if (bus.in_eof) eof_seen <= 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers define which entries are valid, and leaving it unreset lets
    // it map onto plain RAM.
    if (push) mem[wr_ptr] <= bus.in_byte;
  end

  // Read result register, loaded only in DOWORK and held through the ack.
  always_ff @(posedge clk) begin
    if (areset) begin
      data_q <= '0;
    end else if (state_q == IO_DOWORK) begin
      if (have_byte) data_q <= WORD_SIZE'(mem[rd_ptr]);
      else           data_q <= '1;
    end
  end

endmodule

// File: tb/tb_io_input.sv
// Scoreboard bench for io_input (DEPTH=4, WORD_SIZE=32). Stimulus queues the
// expected word for each read; a monitor compares on every rising ack.
module tb_io_input;

  localparam int WS = 32;
  localparam int DP = 4;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic clk;
  logic areset;

  io_input_if #(.WORD_SIZE(WS), .DEPTH(DP)) bus ();

  io_input #(.DEPTH(DP), .WORD_SIZE(WS)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic        ack_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: score every new ack against the oldest queued expectation, and
  // make sure the FIFO never advertises space while full.
  always @(negedge clk) begin
    if (bus.ack && !ack_q) begin
      if (exp_q.size() == 0) check("unexpected_ack", 32'(bus.ack), 32'd0);
      else                   check("read_data", bus.data, exp_q.pop_front());
    end
    if (bus.count == 3'(DP)) check("ready_when_full", 32'(bus.in_ready), 32'd0);
    ack_q = bus.ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic eof);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_eof   = eof;
    tick();
    bus.in_valid = 1'b0;
    bus.in_eof   = 1'b0;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!bus.ack && n < 50) begin
      tick();
      n++;
    end
    check("ack_rise", 32'(bus.ack), 32'd1);
  endtask

  task automatic release_req();
    int n = 0;
    bus.req = 1'b0;
    while (bus.ack && n < 10) begin
      tick();
      n++;
    end
    check("ack_drop", 32'(bus.ack), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] exp_val);
    exp_q.push_back(exp_val);
    bus.req = 1'b1;
    wait_ack();
    release_req();
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    logic any_ack;
    bus.req      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_eof   = 1'b0;
    areset       = 1'b1;
    tick();
    tick();
    areset = 1'b0;

    // Reset state.
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_data", bus.data, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic read: ack two edges after req is first sampled.
    push_byte(8'h41, 1'b0);
    check("basic_count", 32'(bus.count), 32'd1);
    exp_q.push_back(32'h0000_0041);
    bus.req = 1'b1;
    tick();
    check("basic_ack_n1", 32'(bus.ack), 32'd0);
    tick();
    check("basic_ack_n2", 32'(bus.ack), 32'd1);
    check("basic_data", bus.data, 32'h0000_0041);
    bus.req = 1'b0;
    tick();
    check("basic_ack_fall", 32'(bus.ack), 32'd0);
    check("basic_count_end", 32'(bus.count), 32'd0);

    // Ordering and pointer wrap.
    for (int i = 1; i <= 4; i++) push_byte(8'(i), 1'b0);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    push_byte(8'hEE, 1'b0);  // offered while full, must be ignored
    check("full_no_overwrite", 32'(bus.count), 32'd4);
    do_read(32'h01);
    do_read(32'h02);
    push_byte(8'h05, 1'b0);
    push_byte(8'h06, 1'b0);
    check("wrap_count", 32'(bus.count), 32'd4);
    for (int i = 3; i <= 6; i++) do_read(32'(i));
    check("wrap_empty", 32'(bus.count), 32'd0);

    // Blocking read on an empty FIFO.
    bus.req = 1'b1;
    any_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_ack |= bus.ack;
    end
    check("blocking_no_ack", 32'(any_ack), 32'd0);
    exp_q.push_back(32'h7A);
    push_byte(8'h7A, 1'b0);  // push edge P: count becomes 1
    tick();                  // P+1: WAITREQ sees the byte -> DOWORK
    check("blocking_ack_p1", 32'(bus.ack), 32'd0);
    tick();                  // P+2: WAITACK
    check("blocking_ack_p2", 32'(bus.ack), 32'd1);
    check("blocking_data", bus.data, 32'h7A);
    release_req();

    // Simultaneous push and pop during DOWORK.
    push_byte(8'h31, 1'b0);
    push_byte(8'h32, 1'b0);
    exp_q.push_back(32'h31);
    bus.req = 1'b1;
    tick();                  // now in DOWORK
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h33;
    tick();
    bus.in_valid = 1'b0;
    check("simul_count", 32'(bus.count), 32'd2);
    check("simul_data", bus.data, 32'h31);
    release_req();
    do_read(32'h32);
    do_read(32'h33);

    // End of stream: buffered bytes first, then all ones forever.
    push_byte(8'h10, 1'b0);
    push_byte(8'h11, 1'b1);
    check("eof_ready", 32'(bus.in_ready), 32'd0);
    check("eof_count", 32'(bus.count), 32'd2);
    do_read(32'h10);
    do_read(32'h11);
    do_read(ALL_ONES);
    do_read(ALL_ONES);
    pulse_reset();

    // Reset in the middle of a handshake, with EOF already seen.
    push_byte(8'h20, 1'b0);
    push_byte(8'h21, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h23, 1'b1);
    exp_q.push_back(32'h20);
    bus.req = 1'b1;
    wait_ack();
    check("midrst_pre_count", 32'(bus.count), 32'd3);
    pulse_reset();
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_data", bus.data, 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    any_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_ack |= bus.ack;
    end
    check("midrst_blocks", 32'(any_ack), 32'd0);
    exp_q.push_back(32'h55);
    push_byte(8'h55, 1'b0);
    wait_ack();
    release_req();

    tick();
    tick();
    check("reads_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
